// File: rtl/state_machine_decryptor.sv
`default_nettype none
// ============================================================================
//  Module   : state_machine_decryptor
//  Purpose  : Control FSM for the AES-128 decryptor. Latches a ciphertext,
//             then sequences the external inverse-round units (AddRoundKey,
//             InvShiftRows, InvSubBytes, InvMixColumns) over the shared
//             Text/ModifiedText bus, steps the round-key selector and
//             presents the plaintext with a ready flag.
//  Ports    : Clk, Rst (async, active-high)
//             En            start request, sampled in IDLE; held in DONE
//             CT            ciphertext, latched in LOAD
//             SelKey        round-key index (NR down to 0)
//             Ry / PT       plaintext valid / plaintext
//             AddEn..MixEn  unit enables (one-hot in op states)
//             AddRy..MixRy  unit done flags
//             Text          current state word (internal data register)
//             ModifiedText  result returned by the active unit
//  Options  : READY_EDGE_EN - when defined, a unit completes only on a
//             rising edge of its ready flag; otherwise readies are levels.
//  Revision : 1.0 - initial release
// ============================================================================
module state_machine_decryptor #(
    parameter int NR = 10,
    parameter int DW = 128
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          En,
    input  logic [DW-1:0] CT,
    output logic [3:0]    SelKey,
    output logic          Ry,
    output logic [DW-1:0] PT,
    output logic          AddEn,
    output logic          SubEn,
    output logic          ShiftEn,
    output logic          MixEn,
    input  logic          AddRy,
    input  logic          SubRy,
    input  logic          ShiftRy,
    input  logic          MixRy,
    output logic [DW-1:0] Text,
    input  logic [DW-1:0] ModifiedText
);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_LOAD     = 4'd1;
    localparam logic [3:0] c_ADD_INIT = 4'd2;
    localparam logic [3:0] c_SHIFT    = 4'd3;
    localparam logic [3:0] c_SUB      = 4'd4;
    localparam logic [3:0] c_ADD      = 4'd5;   // round-key add; the last one (round 0) is the final add
    localparam logic [3:0] c_MIX      = 4'd6;
    localparam logic [3:0] c_DONE     = 4'd7;

    localparam logic [3:0] c_ROUNDS = 4'(NR);

    logic [3:0]    r_state;
    logic [3:0]    w_nextState;
    logic [DW-1:0] r_data;
    logic [DW-1:0] r_pt;
    logic [3:0]    r_round;

    logic w_addFire;
    logic w_subFire;
    logic w_shiftFire;
    logic w_mixFire;
    logic w_capture;
    logic w_decRound;
    logic w_finish;

`ifdef READY_EDGE_EN
    // Previous-cycle copies of the readies: a completion needs a fresh
    // 0->1 transition, so a flag left high by an earlier op is not reused.
    logic r_addRyQ;
    logic r_subRyQ;
    logic r_shiftRyQ;
    logic r_mixRyQ;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_addRyQ   <= 1'b0;
            r_subRyQ   <= 1'b0;
            r_shiftRyQ <= 1'b0;
            r_mixRyQ   <= 1'b0;
        end else begin
            r_addRyQ   <= AddRy;
            r_subRyQ   <= SubRy;
            r_shiftRyQ <= ShiftRy;
            r_mixRyQ   <= MixRy;
        end
    end

    assign w_addFire   = AddRy   & ~r_addRyQ;
    assign w_subFire   = SubRy   & ~r_subRyQ;
    assign w_shiftFire = ShiftRy & ~r_shiftRyQ;
    assign w_mixFire   = MixRy   & ~r_mixRyQ;
`else
    assign w_addFire   = AddRy;
    assign w_subFire   = SubRy;
    assign w_shiftFire = ShiftRy;
    assign w_mixFire   = MixRy;
`endif

    // Next-state logic. Each op state only listens to its own unit's ready,
    // which makes stray readies from other units harmless.
    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        w_decRound  = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (En) w_nextState = c_LOAD;
            end
            c_LOAD: begin
                w_nextState = c_ADD_INIT;
            end
            c_ADD_INIT: begin
                if (w_addFire) begin
                    w_capture   = 1'b1;
                    w_decRound  = 1'b1;
                    w_nextState = c_SHIFT;
                end
            end
            c_SHIFT: begin
                if (w_shiftFire) begin
                    w_capture   = 1'b1;
                    w_nextState = c_SUB;
                end
            end
            c_SUB: begin
                if (w_subFire) begin
                    w_capture   = 1'b1;
                    w_nextState = c_ADD;
                end
            end
            c_ADD: begin
                if (w_addFire) begin
                    w_capture = 1'b1;
                    // Round 0 is the final round: no InvMixColumns follows.
                    if (r_round != 4'd0) begin
                        w_nextState = c_MIX;
                    end else begin
                        w_finish    = 1'b1;
                        w_nextState = c_DONE;
                    end
                end
            end
            c_MIX: begin
                if (w_mixFire) begin
                    w_capture   = 1'b1;
                    w_decRound  = 1'b1;
                    w_nextState = c_SHIFT;
                end
            end
            c_DONE: begin
                if (!En) w_nextState = c_IDLE;
            end
            default: begin
                w_nextState = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= c_IDLE;
            r_data  <= '0;
            r_round <= c_ROUNDS;
            r_pt    <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == c_LOAD) begin
                r_data  <= CT;
                r_round <= c_ROUNDS;
                r_pt    <= '0;
            end else begin
                if (w_capture)  r_data  <= ModifiedText;
                if (w_decRound) r_round <= r_round - 4'd1;
                // Plaintext is taken straight from the bus so it is valid
                // in the same cycle Ry rises.
                if (w_finish)   r_pt    <= ModifiedText;
            end
        end
    end

    assign AddEn   = (r_state == c_ADD_INIT) || (r_state == c_ADD);
    assign ShiftEn = (r_state == c_SHIFT);
    assign SubEn   = (r_state == c_SUB);
    assign MixEn   = (r_state == c_MIX);
    assign Ry      = (r_state == c_DONE);
    assign SelKey  = r_round;
    assign Text    = r_data;
    assign PT      = r_pt;

endmodule
`default_nettype wire

// File: tb/tb_state_machine_decryptor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_state_machine_decryptor
//  Purpose  : Self-checking bench for state_machine_decryptor. A phase-level
//             model (idle / load / op list / done) predicts Text, SelKey,
//             enables, Ry and PT every cycle; directed checks pin key points.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_state_machine_decryptor;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         En  = 1'b1;
    logic [127:0] CT  = '0;
    logic [3:0]   SelKey;
    logic         Ry;
    logic [127:0] PT;
    logic         AddEn, SubEn, ShiftEn, MixEn;
    logic         AddRy = 1'b0, SubRy = 1'b0, ShiftRy = 1'b0, MixRy = 1'b0;
    logic [127:0] Text;
    logic [127:0] ModifiedText = '0;

    state_machine_decryptor #(.NR(10), .DW(128)) dut (
        .Clk(Clk), .Rst(Rst), .En(En), .CT(CT),
        .SelKey(SelKey), .Ry(Ry), .PT(PT),
        .AddEn(AddEn), .SubEn(SubEn), .ShiftEn(ShiftEn), .MixEn(MixEn),
        .AddRy(AddRy), .SubRy(SubRy), .ShiftRy(ShiftRy), .MixRy(MixRy),
        .Text(Text), .ModifiedText(ModifiedText)
    );

    always #5 Clk = ~Clk;

    int nCmp = 0;
    int nBad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Op list: kind 0=Add 1=Shift 2=Sub 3=Mix, plus the key each op sees.
    int         opKind[40];
    logic [3:0] opKey[40];

    task automatic buildTable();
        int n = 0;
        int k = 10;
        opKind[n] = 0; opKey[n] = 4'(k); n++; k--;
        for (int r = 0; r < 9; r++) begin
            for (int s = 0; s < 4; s++) begin
                opKind[n] = (s == 0) ? 1 : (s == 1) ? 2 : (s == 2) ? 0 : 3;
                opKey[n]  = 4'(k);
                n++;
            end
            k--;
        end
        for (int s = 0; s < 3; s++) begin
            opKind[n] = (s == 0) ? 1 : (s == 1) ? 2 : 0;
            opKey[n]  = 4'(k);
            n++;
        end
    endtask

    function automatic logic [3:0] kindMask(input int k);
        case (k)
            0:       return 4'b1000;
            1:       return 4'b0100;
            2:       return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    // Behavioural model
    typedef enum int {P_IDLE, P_LOAD, P_OPS, P_DONE} phase_t;
    phase_t       mPhase   = P_IDLE;
    int           mIdx     = 0;
    logic [127:0] mData    = '0;
    logic [127:0] mPT      = '0;
    logic [3:0]   mKey     = 4'd10;
    bit           mPtKnown = 1'b1;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            mPhase   <= P_IDLE;
            mIdx     <= 0;
            mData    <= '0;
            mPT      <= '0;
            mKey     <= 4'd10;
            mPtKnown <= 1'b1;
        end else begin
            case (mPhase)
                P_IDLE: if (En) mPhase <= P_LOAD;
                P_LOAD: begin
                    mData    <= CT;
                    mKey     <= opKey[0];
                    mIdx     <= 0;
                    mPtKnown <= 1'b0;
                    mPhase   <= P_OPS;
                end
                P_OPS: begin
                    if ((kindMask(opKind[mIdx]) & {AddRy, ShiftRy, SubRy, MixRy}) != 4'b0) begin
                        mData <= ModifiedText;
                        if (mIdx == 39) begin
                            mPT      <= ModifiedText;
                            mPtKnown <= 1'b1;
                            mPhase   <= P_DONE;
                        end else begin
                            mIdx <= mIdx + 1;
                            mKey <= opKey[mIdx + 1];
                        end
                    end
                end
                P_DONE: if (!En) mPhase <= P_IDLE;
                default: mPhase <= P_IDLE;
            endcase
        end
    end

    // Per-cycle compare against the model
    always @(negedge Clk) begin
        chk("text", Text, mData);
        chk("selkey", {124'd0, SelKey}, {124'd0, mKey});
        chk("ry", {127'd0, Ry}, {127'd0, (mPhase == P_DONE)});
        chk("enables", {124'd0, AddEn, ShiftEn, SubEn, MixEn},
            {124'd0, (mPhase == P_OPS) ? kindMask(opKind[mIdx]) : 4'b0});
        if (mPtKnown) chk("pt", PT, mPT);
    end

    function automatic logic [3:0] ens();
        return {AddEn, ShiftEn, SubEn, MixEn};
    endfunction

    // Answer the currently enabled unit after dly idle cycles.
    task automatic doOp(input int idx, input int dly);
        int waited = 0;
        while (ens() == 4'b0 && waited < 20) begin
            @(negedge Clk);
            waited++;
        end
        if (ens() == 4'b0) begin
            nCmp++;
            nBad++;
            $display("FAIL op%0d_timeout: enables got 0 want nonzero", idx);
        end else begin
            ModifiedText = 128'(idx + 1);
            repeat (dly) @(negedge Clk);
            {AddRy, ShiftRy, SubRy, MixRy} = ens();
            @(negedge Clk);
            {AddRy, ShiftRy, SubRy, MixRy} = 4'b0;
        end
    endtask

    initial begin
        buildTable();
        CT = 128'h00112233445566778899AABBCCDDEEFF;

        // Reset held with En high
        repeat (3) @(negedge Clk);
        chk("rst_pt", PT, 128'h0);
        chk("rst_ry", {127'd0, Ry}, 128'd0);
        chk("rst_en", {124'd0, ens()}, 128'd0);
        chk("rst_key", {124'd0, SelKey}, 128'd10);
        Rst = 1'b0;
        En  = 1'b0;
        repeat (3) @(negedge Clk);
        chk("idle_en", {124'd0, ens()}, 128'd0);
        chk("idle_text", Text, 128'h0);

        // Start: IDLE -> LOAD -> ADD_INIT
        En = 1'b1;
        repeat (2) @(negedge Clk);
        chk("start_text", Text, 128'h00112233445566778899AABBCCDDEEFF);
        chk("start_add", {124'd0, ens()}, 128'b1000);
        chk("start_key", {124'd0, SelKey}, 128'd10);
        repeat (3) @(negedge Clk);
        chk("stall_text", Text, 128'h00112233445566778899AABBCCDDEEFF);
        chk("stall_add", {127'd0, AddEn}, 128'd1);
        En = 1'b0;

        // Full sequence with varied latencies and a wrong-ready burst
        for (int i = 0; i < 40; i++) begin
            if (i == 1) begin
                {AddRy, SubRy, MixRy} = 3'b111;
                repeat (5) @(negedge Clk);
                {AddRy, SubRy, MixRy} = 3'b000;
                chk("wr_shift", {127'd0, ShiftEn}, 128'd1);
                chk("wr_text", Text, 128'h1);
                chk("wr_key", {124'd0, SelKey}, 128'd9);
            end
            if (i == 39) En = 1'b1;
            doOp(i, i % 3);
        end
        chk("done_ry", {127'd0, Ry}, 128'd1);
        chk("done_pt", PT, 128'h28);
        repeat (10) @(negedge Clk);
        chk("hold_ry", {127'd0, Ry}, 128'd1);
        chk("hold_pt", PT, 128'h28);
        En = 1'b0;
        @(negedge Clk);
        chk("back_idle_ry", {127'd0, Ry}, 128'd0);
        chk("back_idle_pt", PT, 128'h28);
        chk("back_idle_en", {124'd0, ens()}, 128'd0);

        // Second run, aborted during the SelKey=5 MIX
        CT = 128'hFEDCBA98765432100123456789ABCDEF;
        En = 1'b1;
        repeat (2) @(negedge Clk);
        chk("s2_text", Text, 128'hFEDCBA98765432100123456789ABCDEF);
        chk("s2_key", {124'd0, SelKey}, 128'd10);
        for (int i = 0; i < 40; i++) begin
            if (opKind[i] == 3 && opKey[i] == 4'd5) break;
            doOp(i, 1);
        end
        chk("ab_mix", {127'd0, MixEn}, 128'd1);
        chk("ab_key", {124'd0, SelKey}, 128'd5);
        #2 Rst = 1'b1;
        #1;
        chk("ab_rst_key", {124'd0, SelKey}, 128'd10);
        chk("ab_rst_text", Text, 128'h0);
        chk("ab_rst_pt", PT, 128'h0);
        chk("ab_rst_ry", {127'd0, Ry}, 128'd0);
        chk("ab_rst_en", {124'd0, ens()}, 128'd0);
        CT = 128'h0F0E0D0C0B0A09080706050403020100;
        @(negedge Clk);
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        chk("s3_text", Text, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("s3_key", {124'd0, SelKey}, 128'd10);

        // Third run, back-to-back handshakes
        for (int i = 0; i < 40; i++) doOp(i, 0);
        chk("s3_ry", {127'd0, Ry}, 128'd1);
        chk("s3_pt", PT, 128'h28);
        En = 1'b0;
        @(negedge Clk);
        chk("s3_idle_ry", {127'd0, Ry}, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
`default_nettype wire
